bch_15_7_encoder: RTL and testbench

Systematic BCH(15,7) double-error-correcting encoder over GF(2^4) (t=2), generator g(x) = x^8+x^7+x^6+x^4+1. It is the transmit-side counterpart of the syndrome / Berlekamp-Massey decoding chain. It accepts a 7-bit message on a valid/ready handshake and computes the 8 parity bits with a bit-serial LFSR, one message bit per cycle. It presents the 15-bit codeword on a second valid/ready handshake.

---
 rtl/bch_15_7_encoder_if.sv | 40 ++++
 rtl/bch_15_7_encoder.sv | 110 +++++++++++
 tb/tb_bch_15_7_encoder.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bch_15_7_encoder_if.sv
// rtl/bch_15_7_encoder_if.sv - message-in / codeword-out handshake bundle for the BCH(15,7) encoder
//
// Signals:
//   in_valid   message present on msg
//   in_ready   encoder can accept a message this cycle
//   msg[6:0]   message, msg[6] is the coefficient of x^6
//   out_valid  codeword valid
//   out_ready  sink accepts the codeword this cycle
//   codeword   codeword[i] is the coefficient of x^i; [14:8] = msg, [7:0] = parity
//
// Modports:
//   slave   the encoder side
//   master  the side that supplies messages and sinks codewords

interface bch_15_7_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  msg;
    logic        out_valid;
    logic        out_ready;
    logic [14:0] codeword;

    modport slave (
        input  in_valid,
        input  msg,
        output in_ready,
        output out_valid,
        input  out_ready,
        output codeword
    );

    modport master (
        output in_valid,
        output msg,
        input  in_ready,
        input  out_valid,
        output out_ready,
        input  codeword
    );
endinterface

// File: rtl/bch_15_7_encoder.sv
// rtl/bch_15_7_encoder.sv - systematic BCH(15,7) t=2 encoder, bit-serial LFSR, g(x)=x^8+x^7+x^6+x^4+1
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   bus   handshake bundle (slave modport): message in, codeword out
//   busy  high while a word is being shifted or is waiting to be taken
//
// The codeword is c(x) = m(x)*x^8 + (m(x)*x^8 mod g(x)). The 8 parity bits are
// built one message bit per cycle, MSB first, in a Galois-style divider LFSR.
// Accept edge -> 7 shift edges -> codeword presented with out_valid.

module bch_15_7_encoder (
    input  logic                      clk,
    input  logic                      rst,
    bch_15_7_encoder_if.slave         bus,
    output logic                      busy
);

    // g(x) without its x^8 term; the x^8 term is the bit shifted out of par[7].
    localparam logic [7:0] GEN_LOW = 8'hD1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        OUT   = 2'd2
    } state_t;

    state_t      state;
    logic [6:0]  msg_r;
    logic [6:0]  sh;
    logic [7:0]  par;
    logic [2:0]  cnt;
    logic        out_valid_r;
    logic [14:0] codeword_r;

    logic        fb;
    logic [7:0]  par_next;
    logic        accept;

    // One division step: the next message bit enters at the top, combined with
    // the bit leaving the remainder register.
    always_comb begin
        fb       = sh[6] ^ par[7];
        par_next = {par[6:0], 1'b0} ^ (fb ? GEN_LOW : 8'h00);
    end

    // Combinational through out_ready so a waiting codeword and a new message
    // can swap on the same edge, giving one word per 8 cycles back to back.
    assign bus.in_ready  = (state == IDLE) || ((state == OUT) && bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;

    assign bus.out_valid = out_valid_r;
    assign bus.codeword  = codeword_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            msg_r       <= 7'd0;
            sh          <= 7'd0;
            par         <= 8'd0;
            cnt         <= 3'd0;
            out_valid_r <= 1'b0;
            codeword_r  <= 15'd0;
            busy        <= 1'b0;
        end else if (accept) begin
            // Covers both IDLE and the OUT-handshake-plus-new-message case;
            // in the latter the old codeword is retired on this same edge.
            state       <= SHIFT;
            msg_r       <= bus.msg;
            sh          <= bus.msg;
            par         <= 8'd0;
            cnt         <= 3'd0;
            out_valid_r <= 1'b0;
            busy        <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    busy <= 1'b0;
                end
                SHIFT: begin
                    par <= par_next;
                    sh  <= {sh[5:0], 1'b0};
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd6) begin
                        // Seventh step: par_next is the finished remainder.
                        state       <= OUT;
                        codeword_r  <= {msg_r, par_next};
                        out_valid_r <= 1'b1;
                    end
                end
                OUT: begin
                    // codeword_r is left untouched so it is stable under
                    // backpressure and keeps its value after the handshake.
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_r <= 1'b0;
                        busy        <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid_r <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bch_15_7_encoder.sv
// tb/tb_bch_15_7_encoder.sv - self-checking bench for bch_15_7_encoder

module tb_bch_15_7_encoder;

    logic clk;
    logic rst;
    logic busy;

    bch_15_7_encoder_if bus();

    bch_15_7_encoder dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [6:0]  msg;
        logic [14:0] cw;
    } vec_t;

    vec_t vecs[4];

    logic [14:0] sb[$];
    logic [6:0]  tx[$];
    int          hs_cyc[$];
    int          handoffs;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Long division by g(x) = 0x1D1.
    function automatic logic [14:0] enc_model(input logic [6:0] m);
        logic [14:0] r;
        r = {m, 8'h00};
        for (int i = 14; i >= 8; i--) begin
            if (r[i]) r = r ^ (15'h01D1 << (i - 8));
        end
        return {m, r[7:0]};
    endfunction

    // GF(16) with x^4+x+1: alpha^n.
    function automatic logic [3:0] gf_pow(input int n);
        logic [3:0] a;
        a = 4'd1;
        for (int k = 0; k < (n % 15); k++) a = {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
        return a;
    endfunction

    // {S1, S3}; both zero means the BM decoder yields lambda1 = lambda2 = 0.
    function automatic logic [7:0] syndromes(input logic [14:0] c);
        logic [3:0] s1, s3;
        s1 = 4'd0;
        s3 = 4'd0;
        for (int i = 0; i < 15; i++) begin
            if (c[i]) begin
                s1 = s1 ^ gf_pow(i);
                s3 = s3 ^ gf_pow(3 * i);
            end
        end
        return {s1, s3};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Scoreboard-driven run: sends everything in tx, checks every output.
    task automatic run(input int n_out, input int iv_pct, input int or_pct, input int max_cyc);
        int          cyc;
        int          got;
        logic        hold;
        logic [14:0] held;
        cyc  = 0;
        got  = 0;
        hold = 1'b0;
        held = '0;
        while (got < n_out && cyc < max_cyc) begin
            bus.in_valid  = (tx.size() > 0) && ($urandom_range(99) < iv_pct);
            bus.msg       = bus.in_valid ? tx[0] : 7'($urandom);
            bus.out_ready = ($urandom_range(99) < or_pct);
            #1;
            if (hold) begin
                chk("hold_valid", 32'(bus.out_valid), 32'd1);
                chk("hold_codeword", 32'(bus.codeword), 32'(held));
            end
            hold = bus.out_valid && !bus.out_ready;
            held = bus.codeword;
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 32'(bus.codeword), 32'hFFFF_FFFF);
                end else begin
                    chk("sb_codeword", 32'(bus.codeword), 32'(sb.pop_front()));
                end
                chk("syndrome_zero", 32'(syndromes(bus.codeword)), 32'd0);
                hs_cyc.push_back(cyc);
                if (bus.in_valid && bus.in_ready) handoffs++;
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back(enc_model(bus.msg));
                void'(tx.pop_front());
            end
            tick();
            cyc++;
        end
        if (got < n_out) chk("run_timeout", 32'(got), 32'(n_out));
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int n;
        vecs[0] = '{msg: 7'h00, cw: 15'h0000};
        vecs[1] = '{msg: 7'h01, cw: 15'h01D1};
        vecs[2] = '{msg: 7'h40, cw: 15'h40E8};
        vecs[3] = '{msg: 7'h7F, cw: 15'h7FFF};

        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.msg       = 7'h55;
        bus.out_ready = 1'b0;
        handoffs      = 0;
        tick();
        tick();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_codeword", 32'(bus.codeword), 32'd0);
        rst = 1'b1;
        tick();

        // Table vectors: latency, value, and msg ignored during SHIFT.
        for (int v = 0; v < 4; v++) begin
            bus.in_valid  = 1'b1;
            bus.msg       = vecs[v].msg;
            bus.out_ready = 1'b0;
            #1;
            chk("vec_in_ready", 32'(bus.in_ready), 32'd1);
            tick();
            bus.in_valid = 1'b0;
            bus.msg      = ~vecs[v].msg;
            #1;
            chk("vec_shift_busy", 32'(busy), 32'd1);
            chk("vec_shift_in_ready", 32'(bus.in_ready), 32'd0);
            n = 0;
            while (!bus.out_valid && n < 20) begin
                tick();
                n++;
            end
            chk("vec_latency", 32'(n), 32'd7);
            chk("vec_codeword", 32'(bus.codeword), 32'(vecs[v].cw));
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
            #1;
            chk("vec_post_valid", 32'(bus.out_valid), 32'd0);
            chk("vec_post_busy", 32'(busy), 32'd0);
        end

        // Backpressure for 5 cycles while a second message waits.
        bus.in_valid = 1'b1;
        bus.msg      = 7'h01;
        tick();
        bus.msg = 7'h40;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_codeword", 32'(bus.codeword), 32'h01D1);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        #1;
        chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
        chk("bp_release_idle", 32'(bus.in_ready), 32'd1);
        chk("bp_release_busy", 32'(busy), 32'd0);
        tick();

        // Back-to-back.
        tx.push_back(7'h01);
        tx.push_back(7'h40);
        tx.push_back(7'h7F);
        hs_cyc.delete();
        handoffs = 0;
        run(3, 100, 100, 60);
        if (hs_cyc.size() == 3) begin
            chk("b2b_first_latency", 32'(hs_cyc[0]), 32'd8);
            chk("b2b_spacing0", 32'(hs_cyc[1] - hs_cyc[0]), 32'd8);
            chk("b2b_spacing1", 32'(hs_cyc[2] - hs_cyc[1]), 32'd8);
        end
        chk("b2b_handoffs", 32'(handoffs), 32'd2);
        tick();

        // Asynchronous reset mid-shift.
        bus.in_valid = 1'b1;
        bus.msg      = 7'h7F;
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_codeword", 32'(bus.codeword), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (bus.out_valid) n++;
            tick();
        end
        chk("arst_no_output", 32'(n), 32'd0);
        tx.push_back(7'h01);
        run(1, 100, 100, 30);

        // All 128 messages with random gaps.
        for (int m = 0; m < 128; m++) tx.push_back(7'(m));
        run(128, 60, 50, 20000);
        chk("sweep_sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
